twdl_seq_ctrl: RTL

//  Per-stage sequencer for the Cooley-Tukey twiddle multiplier in the radix engine.
//  - Latches a stage configuration, then admits the stage's butterflies one per handshake.
//  - For each admitted butterfly, drives factor, twdl_numrtr[0:4] and twdl_demontr to the twiddle block.
//  - Counts the twiddle block's returned out_val and pulses done when the stage drains.

---
 rtl/twdl_seq_ctrl_if.sv | 38 +++
 rtl/twdl_seq_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/twdl_seq_ctrl_if.sv
// Bundle between the radix-stage sequencer, its upstream butterfly source and the twiddle block.
// Latency: wires only; timing is owned by the sequencer.
// Backpressure: bf_rdy gates upstream; the twiddle side has none (in_val/out_val only).
interface twdl_seq_ctrl_if #(
    parameter int W_IDX = 12
);
    logic                   cfg_start;
    logic [2:0]             cfg_factor;
    logic [W_IDX-1:0]       cfg_demontr;
    logic [W_IDX-1:0]       cfg_m;
    logic [W_IDX-1:0]       cfg_nbfly;
    logic                   bf_val;
    logic                   bf_rdy;
    logic                   in_val;
    logic [2:0]             factor;
    logic [0:4][W_IDX-1:0]  twdl_numrtr;
    logic [W_IDX-1:0]       twdl_demontr;
    logic                   out_val;
    logic                   busy;
    logic                   done;
    logic                   err_cfg;
    logic                   err_start;
    logic                   err_timeout;

    // Stimulus side: stage config, upstream butterflies and the twiddle block's return.
    modport master (
        output cfg_start, cfg_factor, cfg_demontr, cfg_m, cfg_nbfly, bf_val, out_val,
        input  bf_rdy, in_val, factor, twdl_numrtr, twdl_demontr, busy, done,
               err_cfg, err_start, err_timeout
    );

    // Sequencer side.
    modport slave (
        input  cfg_start, cfg_factor, cfg_demontr, cfg_m, cfg_nbfly, bf_val, out_val,
        output bf_rdy, in_val, factor, twdl_numrtr, twdl_demontr, busy, done,
               err_cfg, err_start, err_timeout
    );
endinterface

// File: rtl/twdl_seq_ctrl.sv
// Per-stage twiddle sequencer: latches a stage config, issues butterflies with lane numerators, counts returns.
// Latency: cfg_start to bf_rdy 1 cycle; accept to in_val 0 cycles; last out_val to done 1 cycle.
// Backpressure: bf_rdy high only in RUN; the twiddle block cannot stall, so every accept is issued.
module twdl_seq_ctrl #(
    parameter int W_IDX   = 12,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    twdl_seq_ctrl_if.slave bus
);
    localparam int W_TO = $clog2(TIMEOUT + 1);
    // The watchdog fires so that err_timeout appears TIMEOUT cycles after the last out_val.
    localparam logic [W_TO-1:0] IDLE_LIMIT = W_TO'(TIMEOUT - 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [2:0]        factor_q;
    logic [W_IDX-1:0]  demontr_q;
    logic [W_IDX-1:0]  m_q;
    logic [W_IDX-1:0]  nbfly_q;
    logic [W_IDX-1:0]  n_q;
    logic [W_IDX-1:0]  iss_cnt_q;
    logic [W_IDX-1:0]  ret_cnt_q;
    logic [W_IDX-1:0]  lane_q [1:4];
    logic [W_TO-1:0]   idle_q;
    logic              err_cfg_q;
    logic              err_start_q;
    logic              err_timeout_q;

    logic [W_IDX+2:0]      cfg_prod;
    logic                  cfg_legal;
    logic                  accept;
    logic                  last_accept;
    logic                  n_wrap;
    logic [W_IDX:0]        ret_sum;
    logic                  drained;
    logic                  timed_out;
    logic                  start_ok;
    logic                  start_bad;
    logic                  start_busy;
    logic                  timeout_hit;
    logic [0:4][W_IDX-1:0] numrtr_d;

    // Config legality and handshake terms; the product is kept full width so a wrapped N is rejected.
    always_comb begin
        cfg_prod    = {{W_IDX{1'b0}}, bus.cfg_factor} * {3'b000, bus.cfg_m};
        cfg_legal   = (bus.cfg_factor >= 3'd2) && (bus.cfg_factor <= 3'd5) &&
                      (bus.cfg_m != '0) && (bus.cfg_nbfly != '0) &&
                      (cfg_prod == {3'b000, bus.cfg_demontr});
        accept      = bus.bf_val && (state_q == RUN);
        last_accept = accept && (iss_cnt_q == nbfly_q - W_IDX'(1));
        n_wrap      = (n_q == m_q - W_IDX'(1));
        ret_sum     = {1'b0, ret_cnt_q} + (W_IDX + 1)'(bus.out_val);
        drained     = ret_sum >= {1'b0, nbfly_q};
        timed_out   = !bus.out_val && (idle_q == IDLE_LIMIT);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and the event strobes that feed the registered error pulses.
    always_comb begin
        state_d     = state_q;
        start_ok    = 1'b0;
        start_bad   = 1'b0;
        start_busy  = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_start) begin
                    if (cfg_legal) begin
                        start_ok = 1'b1;
                        state_d  = RUN;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            RUN: begin
                start_busy = bus.cfg_start;
                if (last_accept) state_d = DRAIN;
            end
            DRAIN: begin
                start_busy = bus.cfg_start;
                if (drained) begin
                    state_d = DONE;
                end else if (timed_out) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            DONE: begin
                start_busy = bus.cfg_start;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Config latch, twiddle index accumulators, issue/return counters and drain watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            factor_q  <= '0;
            demontr_q <= '0;
            m_q       <= '0;
            nbfly_q   <= '0;
            n_q       <= '0;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
            idle_q    <= '0;
            for (int i = 1; i < 5; i++) lane_q[i] <= '0;
        end else if (start_ok) begin
            factor_q  <= bus.cfg_factor;
            demontr_q <= bus.cfg_demontr;
            m_q       <= bus.cfg_m;
            nbfly_q   <= bus.cfg_nbfly;
            n_q       <= '0;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
            idle_q    <= '0;
            for (int i = 1; i < 5; i++) lane_q[i] <= '0;
        end else begin
            if (accept) begin
                iss_cnt_q <= iss_cnt_q + W_IDX'(1);
                // Lane i tracks i*n by adding i per accept; all lanes restart with n at the period end.
                if (n_wrap) begin
                    n_q <= '0;
                    for (int i = 1; i < 5; i++) lane_q[i] <= '0;
                end else begin
                    n_q <= n_q + W_IDX'(1);
                    for (int i = 1; i < 5; i++) lane_q[i] <= lane_q[i] + W_IDX'(i);
                end
            end
            if (bus.out_val && ((state_q == RUN) || (state_q == DRAIN)))
                ret_cnt_q <= ret_cnt_q + W_IDX'(1);
            if ((state_q != DRAIN) || bus.out_val) idle_q <= '0;
            else                                   idle_q <= idle_q + W_TO'(1);
        end
    end

    // One-cycle error pulses, registered from the strobes above.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cfg_q     <= 1'b0;
            err_start_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            err_cfg_q     <= start_bad;
            err_start_q   <= start_busy;
            err_timeout_q <= timeout_hit;
        end
    end

    // Lane outputs: lane 0 is always zero, lanes at or above the radix are masked.
    always_comb begin
        numrtr_d = '0;
        for (int i = 1; i < 5; i++) begin
            if (i < int'(factor_q)) numrtr_d[i] = lane_q[i];
        end
    end

    assign bus.bf_rdy       = (state_q == RUN);
    assign bus.in_val       = accept;
    assign bus.factor       = factor_q;
    assign bus.twdl_numrtr  = numrtr_d;
    assign bus.twdl_demontr = demontr_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign bus.err_cfg      = err_cfg_q;
    assign bus.err_start    = err_start_q;
    assign bus.err_timeout  = err_timeout_q;
endmodule
